f_sweep_checker: RTL and testbench
==================================

# f_sweep_checker

Self-test block that exhaustively drives the 4-input function circuit `F_circuit` and verifies its output. It steps `{a,b,c,d}` through all 16 vectors, holding each for a fixed dwell time, and samples the returned `F` into a 16-bit truth-table signature. It then compares the signature against the expected truth table and reports pass/fail, mismatch count and first failing vector. It sits beside `F_circuit` as its synthesizable stimulus and response end, replacing the manual vector sequence.

## Interface
- `DWELL`, default 2: cycles each vector is held; legal range 1..255.
- `EXPECTED`, default 16'hFF0D: expected signature, where bit i = F for vector i. This is the truth table of F = a | ~b&~d | ~b&c.
- `clk`, input, 1: clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `start`, input, 1: begin a sweep; sampled only in IDLE or DONE.
- `abort`, input, 1: stop the sweep and return to IDLE.
- `a`, `b`, `c`, `d`, output, 1 each: drive to `F_circuit`; vector index = `{a,b,c,d}`, with `a` as MSB.
- `f_in`, input, 1: `F` returned from `F_circuit`.
- `busy`, output, 1: high in DRIVE.
- `done`, output, 1: one-cycle pulse at the end of a sweep.
- `pass`, output, 1: signature == EXPECTED; valid from `done` until the next accepted start.
- `signature`, output, 16: captured truth table.
- `err_count`, output, 5: number of mismatching bits, 0..16.
- `first_fail`, output, 4: lowest failing index; 0 when `err_count`==0.

## Operation
- FSM states: IDLE, DRIVE, DONE.
- IDLE
  - Vector outputs are 0 and `busy` is 0.
  - `start`=1 moves to DRIVE with idx=0, dwell count=0, `signature`, `err_count` and `first_fail` cleared, and `pass`=0.
- DRIVE
  - `{a,b,c,d}` = idx, registered, so there are no glitches.
  - The dwell counter counts 0..DWELL-1.
  - On the edge ending dwell count DWELL-1:
    - `signature[idx]` <= `f_in`.
    - If `f_in` != `EXPECTED[idx]`: `err_count` increments, and `first_fail` <= idx if this is the first error.
    - idx increments and the dwell counter resets.
  - After idx=15 is sampled, the FSM goes to DONE.
- DONE
  - `done`=1 for exactly one cycle.
  - `pass` = (`err_count`==0), evaluated from the completed counts.
  - Next state is IDLE, unless `start`=1 that same cycle, in which case the next state is DRIVE (back-to-back sweep).
  - Results hold in IDLE.
- Abort
  - `abort`=1 in any state returns to IDLE next edge.
  - Vector outputs go to 0 and `done` does not pulse.
  - `signature`, `err_count` and `first_fail` keep their partial values; `pass` stays 0.
  - `abort` takes priority over `start` and over sampling in the same cycle.
- Counter widths
  - idx is 4 bits and never wraps silently; the 15→DONE transition is explicit.
  - The dwell counter is 8 bits.
  - `err_count` saturates naturally at 16 and needs 5 bits.
- `start` asserted while in DRIVE is ignored.

## Timing
- Reset (async assert, sync release) sets:
  - state=IDLE;
  - `a`..`d`=0, `busy`=0, `done`=0, `pass`=0;
  - `signature`=0, `err_count`=0, `first_fail`=0.
- Reset mid-sweep discards all results; there is no `done`.
- `start` is seen at edge k:
  - Vector 0 appears after edge k, and `busy`=1 from the same edge.
  - Vector i is driven during cycles k+1+i·DWELL through k+(i+1)·DWELL.
  - `f_in` is sampled at edge k+(i+1)·DWELL.
- `done` is high in the cycle after edge k+16·DWELL+1. Total latency from `start` to `done` is 16·DWELL+1 edges.
- `f_in` must settle within DWELL cycles of a vector change; the DUT is treated as combinational.
- `busy` drops on the same edge that raises `done`.

## Structure
- Package `f_sweep_pkg`:
  - state enum {IDLE, DRIVE, DONE};
  - `VEC_W`=4, `NUM_VEC`=16;
  - localparam `F_TRUTH`=16'hFF0D, used as the `EXPECTED` default.
- Sub-module `dwell_timer`:
  - loadable 8-bit down-counter with a `clear` input and a `tick` output on terminal count;
  - instantiated once.
- The top level holds the FSM, index register, signature/compare logic, and one `F_circuit` instance in the integration wrapper only, not inside this block.

## Test plan
- Golden sweep: correct `F_circuit` connected, DWELL=2, `start` pulse → `done` 33 edges after `start`; `signature`=16'hFF0D, `pass`=1, `err_count`=0, `first_fail`=0.
- Stuck-at-0 fault: `f_in` tied 0 → `signature`=16'h0000, `err_count`=11, `first_fail`=0, `pass`=0.
- Single-bit fault: `f_in` inverted only for vector 5 → `signature`=16'hFF2D, `err_count`=1, `first_fail`=5, `pass`=0.
- Abort mid-sweep: `abort` during vector 7 → IDLE next edge, `a`..`d`=0, no `done` pulse, `pass`=0; a following `start` gives a full golden result.
- Back-to-back and ignored start: `start` held through DRIVE is ignored; `start` in the DONE cycle begins a second sweep immediately with results cleared, giving a second `done` 33 edges later. Repeat with DWELL=1 → latency 17.
- Async reset mid-sweep: `rst_n` low at vector 9 → all outputs 0 immediately, state IDLE after release, no `done`.

Source files
------------

// File: rtl/f_sweep_pkg.sv
// rtl/f_sweep_pkg.sv - shared types and constants for the F sweep checker
package f_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int VEC_W   = 4;
  localparam int NUM_VEC = 16;

  // Truth table of F = a | ~b&~d | ~b&c, bit i = F for vector i = {a,b,c,d}
  localparam logic [NUM_VEC-1:0] F_TRUTH = 16'hFF0D;

endpackage

// File: rtl/f_sweep_checker_dwell_timer.sv
// rtl/f_sweep_checker_dwell_timer.sv - loadable 8-bit down-counter pacing each vector
module dwell_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] load_val,
  output logic       tick
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Reload on clear or terminal count, otherwise count down while enabled.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = load_val;
    end else if (en) begin
      count_d = (count_q == 8'd0) ? load_val : count_q - 8'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick = en && !clear && (count_q == 8'd0);

endmodule

// File: rtl/f_sweep_checker.sv
// rtl/f_sweep_checker.sv - exhaustive 16-vector stimulus and signature checker for F_circuit
module f_sweep_checker
  import f_sweep_pkg::*;
#(
  parameter int                   DWELL    = 2,
  parameter logic [NUM_VEC-1:0]   EXPECTED = F_TRUTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic               a,
  output logic               b,
  output logic               c,
  output logic               d,
  input  logic               f_in,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [NUM_VEC-1:0] signature,
  output logic [4:0]         err_count,
  output logic [VEC_W-1:0]   first_fail
);

  localparam logic [7:0]       DWELL_M1 = 8'(DWELL - 1);
  localparam logic [VEC_W-1:0] LAST_IDX = VEC_W'(NUM_VEC - 1);

  state_e state_q, state_d;

  logic [VEC_W-1:0]   idx_q, idx_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic               last_q, last_d;
  logic [NUM_VEC-1:0] sig_q, sig_d;
  logic [4:0]         err_q, err_d;
  logic [VEC_W-1:0]   ff_q, ff_d;
  logic               pass_q, pass_d;

  logic start_ok;
  logic timer_clear;
  logic timer_en;
  logic tick;

  // A start is only honoured from IDLE or DONE, and abort always wins.
  assign start_ok = start && !abort && ((state_q == IDLE) || (state_q == DONE));

  dwell_timer u_dwell_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (timer_clear),
    .en       (timer_en),
    .load_val (DWELL_M1),
    .tick     (tick)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: last_q marks that vector 15 has been sampled, so DONE follows one edge later.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (start) state_d = DRIVE;
        DRIVE:   if (last_q) state_d = DONE;
        DONE:    state_d = start ? DRIVE : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State-decoded outputs and timer control.
  always_comb begin
    busy        = (state_q == DRIVE);
    done        = (state_q == DONE);
    timer_clear = (state_q != DRIVE);
    timer_en    = (state_q == DRIVE) && !last_q && !abort;
  end

  // Index stepping, signature capture, error tally and pass evaluation.
  always_comb begin
    idx_d  = idx_q;
    last_d = last_q;
    sig_d  = sig_q;
    err_d  = err_q;
    ff_d   = ff_q;
    pass_d = pass_q;
    if (start_ok) begin
      idx_d  = '0;
      last_d = 1'b0;
      sig_d  = '0;
      err_d  = '0;
      ff_d   = '0;
      pass_d = 1'b0;
    end else if (!abort && (state_q == DRIVE)) begin
      if (tick) begin
        sig_d[idx_q] = f_in;
        if (f_in != EXPECTED[idx_q]) begin
          err_d = err_q + 5'd1;
          if (err_q == 5'd0) begin
            ff_d = idx_q;
          end
        end
        if (idx_q == LAST_IDX) begin
          last_d = 1'b1;
        end else begin
          idx_d = idx_q + VEC_W'(1);
        end
      end else if (last_q) begin
        pass_d = (err_q == 5'd0);
      end
    end
  end

  // Vector outputs are registered so F_circuit never sees a decode glitch.
  always_comb begin
    vec_d = (state_d == DRIVE) ? idx_d : '0;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      vec_q  <= '0;
      last_q <= 1'b0;
      sig_q  <= '0;
      err_q  <= '0;
      ff_q   <= '0;
      pass_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      vec_q  <= vec_d;
      last_q <= last_d;
      sig_q  <= sig_d;
      err_q  <= err_d;
      ff_q   <= ff_d;
      pass_q <= pass_d;
    end
  end

  assign {a, b, c, d} = vec_q;
  assign signature    = sig_q;
  assign err_count    = err_q;
  assign first_fail   = ff_q;
  assign pass         = pass_q;

endmodule

// File: tb/tb_f_sweep_checker.sv
// tb/tb_f_sweep_checker.sv - scoreboard bench for f_sweep_checker
module tb_f_sweep_checker;

  typedef struct {
    logic [15:0] sig;
    logic [4:0]  err;
    logic [3:0]  ff;
    logic        pass;
    int          lat;
    int          sc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, abort;
  logic start, start1;
  int   mode, mode1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic a, b, c, d, f_in, busy, done, pass;
  logic [15:0] signature;
  logic [4:0]  err_count;
  logic [3:0]  first_fail;

  logic a1, b1, c1, d1, f_in1, busy1, done1, pass1;
  logic [15:0] signature1;
  logic [4:0]  err_count1;
  logic [3:0]  first_fail1;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  f_sweep_checker #(.DWELL(2), .EXPECTED(16'hFF0D)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .a(a), .b(b), .c(c), .d(d), .f_in(f_in),
    .busy(busy), .done(done), .pass(pass), .signature(signature),
    .err_count(err_count), .first_fail(first_fail)
  );

  f_sweep_checker #(.DWELL(1), .EXPECTED(16'hFF0D)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort),
    .a(a1), .b(b1), .c(c1), .d(d1), .f_in(f_in1),
    .busy(busy1), .done(done1), .pass(pass1), .signature(signature1),
    .err_count(err_count1), .first_fail(first_fail1)
  );

  // Behavioural F_circuit with fault modes: 0 golden, 1 stuck-at-0, 2 inverted on vector 5
  function automatic logic fval(input int m, input logic [3:0] v);
    logic fa, fb, fc, fd, g;
    {fa, fb, fc, fd} = v;
    g = fa | (~fb & ~fd) | (~fb & fc);
    if (m == 1) return 1'b0;
    if (m == 2 && v == 4'd5) return ~g;
    return g;
  endfunction

  always_comb f_in  = fval(mode,  {a, b, c, d});
  always_comb f_in1 = fval(mode1, {a1, b1, c1, d1});

  function automatic exp_t mk(input int m, input int lat, input int sc);
    exp_t e;
    case (m)
      1:       begin e.sig = 16'h0000; e.err = 5'd11; e.ff = 4'd0; e.pass = 1'b0; end
      2:       begin e.sig = 16'hFF2D; e.err = 5'd1;  e.ff = 4'd5; e.pass = 1'b0; end
      default: begin e.sig = 16'hFF0D; e.err = 5'd0;  e.ff = 4'd0; e.pass = 1'b1; end
    endcase
    e.lat = lat;
    e.sc  = sc;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor for the DWELL=2 instance
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q0.size() == 0) begin
        chk("done0_unexpected", 32'(done), 32'(0));
      end else begin
        e0 = q0.pop_front();
        chk("sig0",  32'(signature),  32'(e0.sig));
        chk("err0",  32'(err_count),  32'(e0.err));
        chk("ff0",   32'(first_fail), 32'(e0.ff));
        chk("pass0", 32'(pass),       32'(e0.pass));
        chk("lat0",  32'(cyc - e0.sc), 32'(e0.lat));
        chk("busy0_at_done", 32'(busy), 32'(0));
      end
    end
  end

  // Monitor for the DWELL=1 instance
  always @(negedge clk) begin
    if (rst_n && done1) begin
      if (q1.size() == 0) begin
        chk("done1_unexpected", 32'(done1), 32'(0));
      end else begin
        e1 = q1.pop_front();
        chk("sig1",  32'(signature1),  32'(e1.sig));
        chk("err1",  32'(err_count1),  32'(e1.err));
        chk("ff1",   32'(first_fail1), 32'(e1.ff));
        chk("pass1", 32'(pass1),       32'(e1.pass));
        chk("lat1",  32'(cyc - e1.sc), 32'(e1.lat));
        chk("busy1_at_done", 32'(busy1), 32'(0));
      end
    end
  end

  task automatic pulse_start(input int m, input bit push);
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    if (push) q0.push_back(mk(m, 33, cyc + 1));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_start1(input int m);
    @(negedge clk);
    mode1  = m;
    start1 = 1'b1;
    q1.push_back(mk(m, 17, cyc + 1));
    @(negedge clk);
    start1 = 1'b0;
  endtask

  task automatic wait_done(input int sel);
    int n = 0;
    while (((sel == 0) ? done : done1) !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'((sel == 0) ? done : done1), 32'(1));
  endtask

  task automatic wait_vec(input logic [3:0] v);
    int n = 0;
    while ({a, b, c, d} !== v && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("vec_reached", 32'({a, b, c, d}), 32'(v));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; start1 = 1'b0; abort = 1'b0; mode = 0; mode1 = 0;
    repeat (3) @(negedge clk);
    chk("rst_sig",  32'(signature),   32'(0));
    chk("rst_err",  32'(err_count),   32'(0));
    chk("rst_ff",   32'(first_fail),  32'(0));
    chk("rst_pass", 32'(pass),        32'(0));
    chk("rst_busy", 32'(busy),        32'(0));
    chk("rst_done", 32'(done),        32'(0));
    chk("rst_vec",  32'({a, b, c, d}), 32'(0));
    rst_n = 1'b1;

    pulse_start(0, 1'b1);
    chk("busy_after_start", 32'(busy), 32'(1));
    wait_done(0);
    repeat (3) @(negedge clk);
    chk("hold_sig",  32'(signature), 32'(16'hFF0D));
    chk("hold_pass", 32'(pass),      32'(1));
    chk("idle_vec",  32'({a, b, c, d}), 32'(0));

    pulse_start(1, 1'b1);
    wait_done(0);
    pulse_start(2, 1'b1);
    wait_done(0);

    // start held well into DRIVE must not restart the sweep
    @(negedge clk);
    mode  = 0;
    start = 1'b1;
    q0.push_back(mk(0, 33, cyc + 1));
    repeat (20) @(negedge clk);
    start = 1'b0;
    wait_done(0);

    // abort while vector 7 is driven; vectors 0..6 sampled stuck-at-0
    pulse_start(1, 1'b0);
    wait_vec(4'd7);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_vec",  32'({a, b, c, d}), 32'(0));
    chk("abort_busy", 32'(busy),       32'(0));
    chk("abort_pass", 32'(pass),       32'(0));
    chk("abort_sig",  32'(signature),  32'(0));
    chk("abort_err",  32'(err_count),  32'(3));
    chk("abort_ff",   32'(first_fail), 32'(0));
    repeat (40) @(negedge clk);
    chk("abort_idle_busy", 32'(busy), 32'(0));
    pulse_start(0, 1'b1);
    wait_done(0);

    // back-to-back: second start in the DONE cycle, results must clear
    pulse_start(1, 1'b1);
    wait_done(0);
    mode  = 0;
    start = 1'b1;
    q0.push_back(mk(0, 33, cyc + 1));
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'(1));
    wait_done(0);

    // DWELL=1 instance, golden then back-to-back with vector-5 fault
    pulse_start1(0);
    wait_done(1);
    mode1  = 2;
    start1 = 1'b1;
    q1.push_back(mk(2, 17, cyc + 1));
    @(negedge clk);
    start1 = 1'b0;
    wait_done(1);

    // async reset during vector 9
    pulse_start(1, 1'b0);
    wait_vec(4'd9);
    rst_n = 1'b0;
    #1;
    chk("arst_vec",  32'({a, b, c, d}), 32'(0));
    chk("arst_busy", 32'(busy),       32'(0));
    chk("arst_done", 32'(done),       32'(0));
    chk("arst_sig",  32'(signature),  32'(0));
    chk("arst_err",  32'(err_count),  32'(0));
    chk("arst_ff",   32'(first_fail), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_rst_busy", 32'(busy),       32'(0));
    chk("post_rst_vec",  32'({a, b, c, d}), 32'(0));

    repeat (5) @(negedge clk);
    chk("q0_drained", 32'(q0.size()), 32'(0));
    chk("q1_drained", 32'(q1.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
